// File: rtl/axis_if.sv
// axis_if: AXI-Stream bundle (valid/ready/data/last) with master and slave views.
interface axis_if #(
    parameter int W = 16
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master(output tvalid, tdata, tlast, input tready);
    modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_diff_filter.sv
// axis_diff_filter: two-stage AXI-Stream differentiator with selectable kernel,
// left gain shift and saturating output with a sticky saturation flag.
module axis_diff_filter #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int HIST_DEPTH = 5
) (
    input  logic       aclk,
    input  logic       aresetn,
    axis_if.slave      s_axis,
    axis_if.master     m_axis,
    input  logic [1:0] cfg_mode,
    input  logic [2:0] cfg_shift,
    input  logic       cfg_clear,
    output logic       sat_flag
);
    localparam int W = AXIS_TDATA_WIDTH;
    localparam int WE = W + 4;
    localparam int WS = WE + 7;
    localparam logic signed [WS-1:0] MAX_V = {{(WS - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [WS-1:0] MIN_V = ~MAX_V;

    if (HIST_DEPTH != 5 || W < 8 || W > 32) begin : g_bad_param
        $fatal(1, "axis_diff_filter: unsupported HIST_DEPTH or AXIS_TDATA_WIDTH");
    end

    // The incoming sample is x[n]; only the four older samples need storage.
    logic [W-1:0]          hist [0:3];
    logic                  en, acc;
    logic signed [WE-1:0]  e [0:4];
    logic signed [WE-1:0]  d1, d2, y, y1;
    logic [2:0]            sh1;
    logic                  last1, v1;
    logic signed [WS-1:0]  ys;
    logic                  clamp, v2, last2;
    logic [W-1:0]          data2;

    function automatic logic signed [WE-1:0] ext(input logic [W-1:0] v);
        return {{4{v[W-1]}}, v};
    endfunction

    assign en = ~v2 | m_axis.tready;
    assign acc = s_axis.tvalid & en;
    assign s_axis.tready = en;
    assign m_axis.tvalid = v2;
    assign m_axis.tdata = data2;
    assign m_axis.tlast = last2;

    always_comb begin
        e[0] = ext(s_axis.tdata);
        for (int i = 1; i < 5; i++) e[i] = cfg_clear ? '0 : ext(hist[i-1]);
        d1 = e[4] - e[0];
        d2 = e[1] - e[3];
        y = cfg_mode == 2'd0 ? e[0] :
            cfg_mode == 2'd1 ? e[0] - e[1] :
            cfg_mode == 2'd2 ? (e[0] - e[2]) >>> 1 :
            (d1 >>> 3) + (d1 >>> 4) + d2 - (d2 >>> 5);
        ys = {{7{y1[WE-1]}}, y1} << sh1;
        clamp = ys > MAX_V || ys < MIN_V;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hist <= '{default: '0};
            v1 <= 1'b0;
            y1 <= '0;
            sh1 <= '0;
            last1 <= 1'b0;
            v2 <= 1'b0;
            data2 <= '0;
            last2 <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            // A clear with a handshake keeps only the new sample.
            if (acc || cfg_clear) begin
                hist[0] <= acc ? s_axis.tdata : '0;
                for (int i = 1; i < 4; i++) hist[i] <= cfg_clear ? '0 : hist[i-1];
            end
            if (en) begin
                v1 <= acc;
                v2 <= v1;
                if (acc) begin
                    y1 <= y;
                    sh1 <= cfg_shift;
                    last1 <= s_axis.tlast;
                end
                if (v1) begin
                    data2 <= clamp ? (ys[WS-1] ? MIN_V[W-1:0] : MAX_V[W-1:0]) : ys[W-1:0];
                    last2 <= last1;
                end
            end
            sat_flag <= (sat_flag & ~cfg_clear) | (en & v1 & clamp);
        end
    end
endmodule

// File: tb/tb_axis_diff_filter.sv
// tb_axis_diff_filter: directed and random-stall checks of axis_diff_filter
// against a scoreboard of bench-computed expected outputs.
module tb_axis_diff_filter;
    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [2:0] cfg_shift = 3'd0;
    logic       cfg_clear = 1'b0;
    logic       sat_flag;
    int         n_cmp = 0;
    int         n_err = 0;
    int         tr_mode = 0;
    logic [16:0] sb[$];
    logic [16:0] q;
    bit          stalled = 0;
    logic [15:0] pd;
    logic        pl;
    int v28[6] = '{0, 0, 0, 100, 100, 100};
    int e28[6] = '{0, 0, 0, 100, 0, 0};
    int e3[10] = '{0, -6, 19, 44, 38, 38, 38, 38, 38, 38};
    int e2[10] = '{0, 16, 32, 32, 32, 32, 32, 32, 32, 32};

    axis_if #(.W(16)) s_bus ();
    axis_if #(.W(16)) m_bus ();

    axis_diff_filter #(.AXIS_TDATA_WIDTH(16), .HIST_DEPTH(5)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis(s_bus),
        .m_axis(m_bus),
        .cfg_mode(cfg_mode),
        .cfg_shift(cfg_shift),
        .cfg_clear(cfg_clear),
        .sat_flag(sat_flag)
    );

    always #5 aclk = ~aclk;

    // tr_mode: 0 always ready, 1 random 50%, 2 never ready
    initial begin
        m_bus.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_bus.tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int s16(input int d);
        logic signed [15:0] t;
        t = d[15:0];
        return int'(t);
    endfunction

    function automatic int sat16(input int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    always @(negedge aclk) begin
        if (stalled) begin
            chk("hold_data", $signed(m_bus.tdata), $signed(pd));
            chk("hold_last", m_bus.tlast, pl);
        end
        if (aresetn && m_bus.tvalid && m_bus.tready) begin
            chk("unexpected_out", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                q = sb.pop_front();
                chk("out_data", $signed(m_bus.tdata), $signed(q[15:0]));
                chk("out_last", m_bus.tlast, q[16]);
            end
        end
        stalled = aresetn && m_bus.tvalid && !m_bus.tready;
        pd = m_bus.tdata;
        pl = m_bus.tlast;
    end

    task automatic send(input int d, input bit l, input int e, input bit clr, input bit push);
        int t = 0;
        bit hs;
        s_bus.tvalid = 1'b1;
        s_bus.tdata = d[15:0];
        s_bus.tlast = l;
        cfg_clear = clr;
        do begin
            @(negedge aclk);
            hs = s_bus.tready;
            @(posedge aclk);
            #1;
            t++;
        end while (!hs && t < 200);
        s_bus.tvalid = 1'b0;
        cfg_clear = 1'b0;
        chk("send_handshake", hs, 1);
        if (hs && push) sb.push_back({l, e[15:0]});
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 1000) begin
            @(posedge aclk);
            #1;
            t++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        int prev;
        int d;
        s_bus.tvalid = 1'b0;
        s_bus.tdata = '0;
        s_bus.tlast = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", m_bus.tvalid, 0);
        chk("rst_tdata", m_bus.tdata, 0);
        chk("rst_tlast", m_bus.tlast, 0);
        chk("rst_sat", sat_flag, 0);
        aresetn = 1'b1;
        chk("rst_tready", s_bus.tready, 1);

        cfg_mode = 2'd1;
        cfg_shift = 3'd0;
        for (int i = 0; i < 6; i++) begin
            send(v28[i], i == 5, e28[i], i == 0, 1);
            chk("lat_stage1", m_bus.tvalid, 0);
            @(posedge aclk);
            #1;
            chk("lat_stage2", m_bus.tvalid, 1);
        end
        drain();

        cfg_mode = 2'd3;
        for (int k = 0; k < 10; k++) send(32 * k, k == 9, e3[k], k == 0, 1);
        drain();
        cfg_mode = 2'd2;
        for (int k = 0; k < 10; k++) send(32 * k, k == 9, e2[k], k == 0, 1);
        drain();
        chk("ramp_no_sat", sat_flag, 0);

        cfg_mode = 2'd1;
        send(32'h8000, 0, -32768, 1, 1);
        send(32'h7fff, 1, 32767, 0, 1);
        drain();
        chk("sat_set", sat_flag, 1);
        cfg_clear = 1'b1;
        @(posedge aclk);
        #1;
        cfg_clear = 1'b0;
        chk("sat_cleared", sat_flag, 0);

        cfg_shift = 3'd2;
        send(0, 0, 0, 1, 1);
        send(100, 0, 400, 0, 1);
        drain();
        chk("shift_no_sat", sat_flag, 0);
        cfg_mode = 2'd0;
        cfg_shift = 3'd7;
        send(300, 1, 32767, 0, 1);
        cfg_shift = 3'd1;
        send(32'hb1e0, 0, -32768, 0, 1);
        drain();
        chk("gain_sat", sat_flag, 1);

        cfg_mode = 2'd1;
        cfg_shift = 3'd0;
        tr_mode = 1;
        prev = 0;
        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 65535));
            send(d, i % 8 == 7, sat16(s16(d) - prev), i == 0, 1);
            prev = s16(d);
        end
        drain();

        tr_mode = 2;
        repeat (2) @(posedge aclk);
        #1;
        send(10, 0, 0, 0, 0);
        send(20, 0, 0, 0, 0);
        chk("inflight_stalled", m_bus.tvalid, 1);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        chk("midrst_tvalid", m_bus.tvalid, 0);
        chk("midrst_sat", sat_flag, 0);
        chk("midrst_tready", s_bus.tready, 1);
        tr_mode = 0;
        repeat (2) @(posedge aclk);
        #1;
        send(50, 1, 50, 0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axis_diff_filter.md
AXIS_DIFF_FILTER -- requirements
Module: axis_diff_filter

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 16, meaning the sample width (signed two's complement, 8..32).
REQ-002 The block SHALL have parameter HIST_DEPTH, default 5, meaning the input-history depth in samples (fixed at 5 for this revision; other values are rejected at elaboration).
REQ-003 The block SHALL provide port aclk, input, 1 bit, the only clock.
REQ-004 The block SHALL provide port aresetn, input, 1 bit, reset that is synchronous and active-low.
REQ-005 The block SHALL provide ports S_AXIS_tvalid (in, 1), S_AXIS_tready (out, 1), S_AXIS_tdata (in, AXIS_TDATA_WIDTH) and S_AXIS_tlast (in, 1), the input stream.
REQ-006 The block SHALL provide ports M_AXIS_tvalid (out, 1), M_AXIS_tready (in, 1), M_AXIS_tdata (out, AXIS_TDATA_WIDTH) and M_AXIS_tlast (out, 1), the output stream.
REQ-007 The block SHALL provide port cfg_mode, input, 2 bits: 0 bypass, 1 first difference, 2 central difference, 3 five-tap wideband differentiator.
REQ-008 The block SHALL provide port cfg_shift, input, 3 bits, a left gain shift of 0..7 applied before saturation.
REQ-009 The block SHALL provide port cfg_clear, input, 1 bit, a single-cycle pulse that zeroes the history and clears sat_flag.
REQ-010 The block SHALL provide port sat_flag, output, 1 bit, a sticky flag meaning an output has saturated.

Function
REQ-011 The block SHALL define a pipeline enable en = ~stage2_valid | M_AXIS_tready, and S_AXIS_tready SHALL equal en.
REQ-012 An input handshake (tvalid & tready) SHALL shift the history (x[n-1]..x[n-4] <= x[n]..x[n-3]) and write S_AXIS_tdata into x[n]; without a handshake the history SHALL hold.
REQ-013 Stage 1 SHALL register, on each accepted sample, the mode-selected terms at AXIS_TDATA_WIDTH+4 bits of full precision, together with tlast, cfg_mode, cfg_shift and a valid bit.
REQ-014 Stage 1 SHALL use the following per-mode results:
- mode 0: y = x[n]
- mode 1: y = x[n] - x[n-1]
- mode 2: y = (x[n] - x[n-2]) >>> 1
- mode 3: d1 = x[n-4] - x[n] and d2 = x[n-1] - x[n-3], with y = (d1>>>3) + (d1>>>4) + d2 - (d2>>>5)
REQ-015 All shifts SHALL be arithmetic, all operands SHALL be sign-extended before subtraction, and no intermediate value SHALL wrap.
REQ-016 Stage 2 SHALL apply y <<< cfg_shift (the value captured in stage 1), then saturate to [-2^(W-1), 2^(W-1)-1], and drive M_AXIS_tdata and M_AXIS_tlast from registers.
REQ-017 Latency SHALL be exactly 2 cycles from the input handshake to M_AXIS_tvalid=1 when M_AXIS_tready is held high, with a throughput of 1 sample per cycle.
REQ-018 When M_AXIS_tvalid=1 and M_AXIS_tready=0, all pipeline registers, M_AXIS_tdata and M_AXIS_tlast SHALL hold stable and S_AXIS_tready SHALL be 0.
REQ-019 Stage valid bits SHALL advance only when en=1, so that bubbles propagate and no sample is ever duplicated or dropped.
REQ-020 sat_flag SHALL be set when stage 2 clamps a value while en=1, and it SHALL remain set until cfg_clear or reset.
REQ-021 When cfg_clear=1 coincides with an input handshake, the history SHALL become {x[n]=S_AXIS_tdata, older=0} and the stage-1 result SHALL use these zeroed values.
REQ-022 cfg_clear SHALL NOT flush samples already in stage 1 or stage 2.
REQ-023 When cfg_clear and a saturation occur in the same cycle, sat_flag SHALL end at 1.
REQ-024 A change of cfg_mode or cfg_shift SHALL affect only samples accepted after the change, and history SHALL be retained across mode changes.
REQ-025 M_AXIS_tlast SHALL be the S_AXIS_tlast of the same sample, delayed through the pipeline.

Reset
REQ-026 While aresetn=0 at a rising aclk edge, the block SHALL clear the history, stage valids, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast and sat_flag to 0, and S_AXIS_tready SHALL read 1 in the cycle after reset.
REQ-027 Reset asserted mid-stream SHALL discard every in-flight sample, and the first sample accepted after reset SHALL see a zero history.

Verification
REQ-028 The bench SHALL cover: mode 1, shift 0, input stream 0,0,0,100,100,100 -> outputs 0,0,0,100,0,0, with M_AXIS_tvalid appearing 2 cycles after each handshake.
REQ-029 The bench SHALL cover: mode 3, ramp x[k]=32k for k=0..9 -> steady-state output 38 from the 5th output onward; mode 2 on the same ramp -> 32 from the 3rd output onward.
REQ-030 The bench SHALL cover: mode 1, input -32768 then 32767 -> second output 32767 and sat_flag=1; then cfg_clear -> sat_flag=0 on the next cycle.
REQ-031 The bench SHALL cover: mode 1, shift 2, step 0 -> 100 -> output 400; mode 0, shift 7, input 300 -> output 32767 with saturation.
REQ-032 The bench SHALL cover: random M_AXIS_tready (50%) with continuous input -> output sequence identical to the tready=1 run, tdata and tlast held stable while stalled, and no loss or duplication.
REQ-033 The bench SHALL cover: aresetn pulsed low for 1 cycle while 2 samples are in flight -> no output for those samples, and the next input 50 in mode 1 -> output 50.
